// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state codes, access-width codes and flag constants.
// Covers both builds, with and without MEM_CTRL_IBUF_EN.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic DONE_ON     = 1'b1;
    localparam logic DONE_OFF    = 1'b0;
    localparam logic BUF_VALID   = 1'b1;
    localparam logic BUF_INVALID = 1'b0;

    localparam logic [2:0] FETCH_LEN = 3'd4;

    // Byte count of a data access; the unused code 11 behaves as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] width);
        logic [2:0] len;
        case (width)
            WIDTH_BYTE: len = 3'd1;
            WIDTH_HALF: len = 3'd2;
            WIDTH_WORD: len = 3'd4;
            default:    len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// One-entry fetch buffer: last fetched word and its fetch address.
// Present only when MEM_CTRL_IBUF_EN is defined.
module mem_ctrl_ibuf
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              refill,
    input  logic [ADDR_W-1:0] refill_addr,
    input  logic [31:0]       refill_data,
    input  logic              inv,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [2:0]        inv_len
);

    localparam logic [ADDR_W-1:0] WORD_SPAN = {{(ADDR_W-3){1'b0}}, 3'd4};

    logic              vld_r;
    logic [ADDR_W-1:0] tag_r;
    logic [31:0]       data_r;
    logic [ADDR_W-1:0] fwd_dist_s;
    logic [ADDR_W-1:0] back_dist_s;
    logic              overlap_s;

    assign hit      = vld_r && (tag_r == lookup_addr);
    assign hit_data = data_r;

    // Modular distance test: the store range and the buffered 4-byte range share a byte.
    always_comb begin
        fwd_dist_s  = inv_addr - tag_r;
        back_dist_s = tag_r - inv_addr;
        if ((fwd_dist_s < WORD_SPAN) || (back_dist_s < {{(ADDR_W-3){1'b0}}, inv_len})) begin
            overlap_s = 1'b1;
        end else begin
            overlap_s = 1'b0;
        end
    end

    // Buffer entry: refilled by completed fetches, dropped by overlapping stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_r  <= BUF_INVALID;
            tag_r  <= {ADDR_W{1'b0}};
            data_r <= 32'd0;
        end else if (refill) begin
            vld_r  <= BUF_VALID;
            tag_r  <= refill_addr;
            data_r <= refill_data;
        end else if (inv && overlap_s) begin
            vld_r  <= BUF_INVALID;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and data load/store.
// Optional fetch buffer enabled by defining MEM_CTRL_IBUF_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [1:0]        mem_width_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_THREE = {{(ADDR_W-2){1'b0}}, 2'b11};

    logic [1:0]        state_r;
    logic [2:0]        cnt_r;
    logic [2:0]        len_r;
    logic              gnt_mem_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rbuf_r;
    logic [31:0]       if_data_r;
    logic              if_done_r;
    logic [31:0]       mem_rdata_r;
    logic              mem_done_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_wr_r;
    logic [7:0]        ram_dout_r;

    logic              idle_ok_s;
    logic              cur_req_s;
    logic [2:0]        mem_len_s;
    logic              mem_grant_s;
    logic              if_hit_s;
    logic              if_grant_s;
    logic [31:0]       asm_s;
    logic [7:0]        wbyte_s;
    logic              ibuf_hit_s;
    logic [31:0]       ibuf_data_s;

    assign if_data_o   = if_data_r;
    assign if_done_o   = if_done_r;
    assign mem_rdata_o = mem_rdata_r;
    assign mem_done_o  = mem_done_r;
    assign ram_addr_o  = ram_addr_r;
    assign ram_wr_o    = ram_wr_r;
    assign ram_dout_o  = ram_dout_r;

    // Requests are ignored during the done cycle so each transaction ends with one idle turn.
    assign idle_ok_s   = (state_r == ST_IDLE) && !if_done_r && !mem_done_r;
    assign cur_req_s   = gnt_mem_r ? mem_req_i : if_req_i;
    assign mem_len_s   = xfer_len(mem_width_i);
    assign mem_grant_s = idle_ok_s && mem_req_i;
    assign if_hit_s    = idle_ok_s && !mem_req_i && if_req_i && ibuf_hit_s;
    assign if_grant_s  = idle_ok_s && !mem_req_i && if_req_i && !ibuf_hit_s;

`ifdef MEM_CTRL_IBUF_EN
    logic refill_s;
    logic inv_s;

    // A fetch completes when its fourth byte is merged; its start is ram_addr_r minus 3.
    assign refill_s = (state_r == ST_READ) && cur_req_s && (cnt_r == len_r) && !gnt_mem_r;
    assign inv_s    = mem_grant_s && mem_we_i;

    mem_ctrl_ibuf #(.ADDR_W(ADDR_W)) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (if_addr_i),
        .hit         (ibuf_hit_s),
        .hit_data    (ibuf_data_s),
        .refill      (refill_s),
        .refill_addr (ram_addr_r - ADDR_THREE),
        .refill_data (asm_s),
        .inv         (inv_s),
        .inv_addr    (mem_addr_i),
        .inv_len     (mem_len_s)
    );
`else
    assign ibuf_hit_s  = 1'b0;
    assign ibuf_data_s = 32'd0;
`endif

    // Merge the byte returned for the previous address into its little-endian lane.
    always_comb begin
        asm_s = rbuf_r;
        case (cnt_r)
            3'd1:    asm_s[7:0]   = ram_din_i;
            3'd2:    asm_s[15:8]  = ram_din_i;
            3'd3:    asm_s[23:16] = ram_din_i;
            3'd4:    asm_s[31:24] = ram_din_i;
            default: asm_s = rbuf_r;
        endcase
    end

    // Store byte for the next write cycle.
    always_comb begin
        case (cnt_r)
            3'd0:    wbyte_s = wdata_r[15:8];
            3'd1:    wbyte_s = wdata_r[23:16];
            3'd2:    wbyte_s = wdata_r[31:24];
            default: wbyte_s = 8'd0;
        endcase
    end

    // Arbitration FSM, RAM port drive and registered completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            len_r       <= 3'd0;
            gnt_mem_r   <= 1'b0;
            wdata_r     <= 32'd0;
            rbuf_r      <= 32'd0;
            if_data_r   <= 32'd0;
            if_done_r   <= DONE_OFF;
            mem_rdata_r <= 32'd0;
            mem_done_r  <= DONE_OFF;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wr_r    <= 1'b0;
            ram_dout_r  <= 8'd0;
        end else begin
            if_done_r  <= DONE_OFF;
            mem_done_r <= DONE_OFF;
            case (state_r)
                ST_IDLE: begin
                    ram_wr_r <= 1'b0;
                    cnt_r    <= 3'd0;
                    if (mem_grant_s) begin
                        gnt_mem_r  <= 1'b1;
                        len_r      <= mem_len_s;
                        rbuf_r     <= 32'd0;
                        wdata_r    <= mem_wdata_i;
                        ram_addr_r <= mem_addr_i;
                        if (mem_we_i) begin
                            state_r    <= ST_WRITE;
                            ram_wr_r   <= 1'b1;
                            ram_dout_r <= mem_wdata_i[7:0];
                        end else begin
                            state_r    <= ST_READ;
                        end
                    end else if (if_hit_s) begin
                        if_done_r <= DONE_ON;
                        if_data_r <= ibuf_data_s;
                    end else if (if_grant_s) begin
                        gnt_mem_r  <= 1'b0;
                        len_r      <= FETCH_LEN;
                        rbuf_r     <= 32'd0;
                        ram_addr_r <= if_addr_i;
                        state_r    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!cur_req_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                    end else if (cnt_r == len_r) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                        if (gnt_mem_r) begin
                            mem_done_r  <= DONE_ON;
                            mem_rdata_r <= asm_s;
                        end else begin
                            if_done_r   <= DONE_ON;
                            if_data_r   <= asm_s;
                        end
                    end else begin
                        rbuf_r <= asm_s;
                        cnt_r  <= cnt_r + 3'd1;
                        if ((cnt_r + 3'd1) < len_r) begin
                            ram_addr_r <= ram_addr_r + ADDR_ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (!cur_req_s) begin
                        state_r  <= ST_IDLE;
                        ram_wr_r <= 1'b0;
                        cnt_r    <= 3'd0;
                    end else if ((cnt_r + 3'd1) == len_r) begin
                        state_r    <= ST_IDLE;
                        ram_wr_r   <= 1'b0;
                        cnt_r      <= 3'd0;
                        mem_done_r <= DONE_ON;
                    end else begin
                        cnt_r      <= cnt_r + 3'd1;
                        ram_addr_r <= ram_addr_r + ADDR_ONE;
                        ram_dout_r <= wbyte_s;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ram_wr_r <= 1'b0;
                    cnt_r    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model (read data one cycle after address).
// Buffer-specific expectations follow MEM_CTRL_IBUF_EN.
module tb_mem_ctrl;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_data;
    logic          if_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [1:0]    mem_width;
    logic [31:0]   mem_rdata;
    logic          mem_done;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram [0:65535];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [7:0]    tb_data;

    int total = 0;
    int bad   = 0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data),
        .if_done_o   (if_done),
        .mem_req_i   (mem_req),
        .mem_we_i    (mem_we),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_width_i (mem_width),
        .mem_rdata_o (mem_rdata),
        .mem_done_o  (mem_done),
        .ram_addr_o  (ram_addr),
        .ram_wr_o    (ram_wr),
        .ram_dout_o  (ram_dout),
        .ram_din_i   (ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= ram[ram_addr];
        if (ram_wr) begin
            ram[ram_addr] <= ram_dout;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        step();
        tb_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = 16'h0000;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 32'h0; mem_width = 2'b00;
        tb_we = 1'b0; tb_addr = 16'h0000; tb_data = 8'h00;
        step();
        poke(16'h0100, 8'h11); poke(16'h0101, 8'h22); poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
        poke(16'h0104, 8'h01); poke(16'h0105, 8'h02); poke(16'h0106, 8'h03); poke(16'h0107, 8'h04);
        poke(16'h0202, 8'h5A); poke(16'h0300, 8'h80); poke(16'h0502, 8'h77);
        poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hBB); poke(16'h0000, 8'hCC); poke(16'h0001, 8'hDD);

        chk("rst_addr", {16'd0, ram_addr}, 32'h0);
        chk("rst_wr", {31'd0, ram_wr}, 32'h0);
        chk("rst_dout", {24'd0, ram_dout}, 32'h0);
        chk("rst_ifdata", if_data, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_dones", {30'd0, if_done, mem_done}, 32'h0);

        // word fetch at 0x100, request sampled in the first cycle after reset release
        rst = 1'b1; if_req = 1'b1; if_addr = 16'h0100;
        step(); chk("f_a0", {16'd0, ram_addr}, 32'h0100); chk("f_wr0", {31'd0, ram_wr}, 32'h0);
        if_addr = 16'h0999;
        step(); chk("f_a1", {16'd0, ram_addr}, 32'h0101);
        step(); chk("f_a2", {16'd0, ram_addr}, 32'h0102);
        step(); chk("f_a3", {16'd0, ram_addr}, 32'h0103);
        step(); chk("f_nodone5", {31'd0, if_done}, 32'h0);
        step(); chk("f_done6", {31'd0, if_done}, 32'h1); chk("f_data", if_data, 32'h44332211);
        if_req = 1'b0;
        step(); chk("f_pulse", {31'd0, if_done}, 32'h0); chk("f_hold", if_data, 32'h44332211);
        chk("idle_addr", {16'd0, ram_addr}, 32'h0103); chk("idle_wr", {31'd0, ram_wr}, 32'h0);

        // half store 0xBEEF to 0x200
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0200; mem_wdata = 32'h1234BEEF; mem_width = 2'b01;
        step(); chk("s_a0", {16'd0, ram_addr}, 32'h0200); chk("s_wr0", {31'd0, ram_wr}, 32'h1);
        chk("s_d0", {24'd0, ram_dout}, 32'hEF);
        mem_wdata = 32'h0; mem_addr = 16'h0000;
        step(); chk("s_a1", {16'd0, ram_addr}, 32'h0201); chk("s_wr1", {31'd0, ram_wr}, 32'h1);
        chk("s_d1", {24'd0, ram_dout}, 32'hBE); chk("s_nodone", {31'd0, mem_done}, 32'h0);
        step(); chk("s_done", {31'd0, mem_done}, 32'h1); chk("s_wr_off", {31'd0, ram_wr}, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0;
        step(); chk("s_pulse", {31'd0, mem_done}, 32'h0);
        chk("s_ram200", {24'd0, ram[16'h0200]}, 32'hEF);
        chk("s_ram201", {24'd0, ram[16'h0201]}, 32'hBE);
        chk("s_ram202", {24'd0, ram[16'h0202]}, 32'h5A);

        // simultaneous requests: byte load wins, fetch follows
        mem_req = 1'b1; mem_addr = 16'h0300; mem_width = 2'b00; if_req = 1'b1; if_addr = 16'h0104;
        step(); chk("arb_a", {16'd0, ram_addr}, 32'h0300); chk("arb_wr", {31'd0, ram_wr}, 32'h0);
        step();
        step(); chk("arb_ldone", {31'd0, mem_done}, 32'h1); chk("arb_ldata", mem_rdata, 32'h00000080);
        chk("arb_fwait", {31'd0, if_done}, 32'h0);
        mem_req = 1'b0;
        step();
        step(); chk("arb_fa0", {16'd0, ram_addr}, 32'h0104);
        repeat (4) step();
        chk("arb_fnd", {31'd0, if_done}, 32'h0);
        step(); chk("arb_fdone", {31'd0, if_done}, 32'h1); chk("arb_fdata", if_data, 32'h04030201);
        chk("arb_rhold", mem_rdata, 32'h00000080);
        if_req = 1'b0;
        step();

        // half load, zero-extended
        mem_req = 1'b1; mem_addr = 16'h0200; mem_width = 2'b01;
        repeat (3) step();
        chk("h_nd", {31'd0, mem_done}, 32'h0);
        step(); chk("h_done", {31'd0, mem_done}, 32'h1); chk("h_data", mem_rdata, 32'h0000BEEF);
        mem_req = 1'b0;
        step();

        // width code 11 loads a full word
        mem_req = 1'b1; mem_addr = 16'h0100; mem_width = 2'b11;
        repeat (5) step();
        chk("w11_nd", {31'd0, mem_done}, 32'h0);
        step(); chk("w11_done", {31'd0, mem_done}, 32'h1); chk("w11_data", mem_rdata, 32'h44332211);
        mem_req = 1'b0;
        step();

        // fetch abandoned mid-way; a load sampled right after proves the FSM is idle
        if_req = 1'b1; if_addr = 16'h0108;
        step(); chk("ab_a0", {16'd0, ram_addr}, 32'h0108);
        step(); chk("ab_a1", {16'd0, ram_addr}, 32'h0109);
        if_req = 1'b0;
        step(); chk("ab_wr", {31'd0, ram_wr}, 32'h0);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0300; mem_width = 2'b00;
        step(); chk("ab_idle", {16'd0, ram_addr}, 32'h0300);
        step();
        step(); chk("ab_nofd", {31'd0, if_done}, 32'h0); chk("ab_ld", {31'd0, mem_done}, 32'h1);
        mem_req = 1'b0;
        step();

        // word store abandoned after two bytes
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0500; mem_wdata = 32'h11223344; mem_width = 2'b10;
        step(); chk("as_d0", {24'd0, ram_dout}, 32'h44);
        step(); chk("as_d1", {24'd0, ram_dout}, 32'h33);
        mem_req = 1'b0;
        step(); chk("as_wr", {31'd0, ram_wr}, 32'h0); chk("as_nd3", {31'd0, mem_done}, 32'h0);
        step(); chk("as_nd4", {31'd0, mem_done}, 32'h0);
        step(); chk("as_nd5", {31'd0, mem_done}, 32'h0);
        chk("as_r500", {24'd0, ram[16'h0500]}, 32'h44);
        chk("as_r501", {24'd0, ram[16'h0501]}, 32'h33);
        chk("as_r502", {24'd0, ram[16'h0502]}, 32'h77);
        mem_we = 1'b0;

        // reset pulse during a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0400; mem_wdata = 32'hA1B2C3D4; mem_width = 2'b10;
        step(); chk("rs_wr", {31'd0, ram_wr}, 32'h1); chk("rs_d0", {24'd0, ram_dout}, 32'hD4);
        step();
        rst = 1'b0;
        #1;
        chk("rs_addr", {16'd0, ram_addr}, 32'h0); chk("rs_wr0", {31'd0, ram_wr}, 32'h0);
        chk("rs_dout", {24'd0, ram_dout}, 32'h0); chk("rs_ifd", if_data, 32'h0);
        chk("rs_rd", mem_rdata, 32'h0);
        step();
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        step(); chk("rs_nd1", {31'd0, mem_done}, 32'h0);
        step(); chk("rs_nd2", {31'd0, mem_done}, 32'h0);
        chk("rs_r400", {24'd0, ram[16'h0400]}, 32'hD4);

        // fetch wrapping past the top of the address space
        if_req = 1'b1; if_addr = 16'hFFFE;
        step(); chk("wr_a0", {16'd0, ram_addr}, 32'hFFFE);
        step(); chk("wr_a1", {16'd0, ram_addr}, 32'hFFFF);
        step(); chk("wr_a2", {16'd0, ram_addr}, 32'h0000);
        step(); chk("wr_a3", {16'd0, ram_addr}, 32'h0001);
        step();
        step(); chk("wr_done", {31'd0, if_done}, 32'h1); chk("wr_data", if_data, 32'hDDCCBBAA);
        if_req = 1'b0;
        step();

        // fetch 0x100, then fetch it again
        if_req = 1'b1; if_addr = 16'h0100;
        step(); chk("b_a0", {16'd0, ram_addr}, 32'h0100);
        repeat (5) step();
        chk("b_done", {31'd0, if_done}, 32'h1); chk("b_data", if_data, 32'h44332211);
        if_req = 1'b0;
        step();
        if_req = 1'b1;
        step();
`ifdef MEM_CTRL_IBUF_EN
        chk("hit_done", {31'd0, if_done}, 32'h1); chk("hit_data", if_data, 32'h44332211);
        chk("hit_noaddr", {16'd0, ram_addr}, 32'h0103); chk("hit_nowr", {31'd0, ram_wr}, 32'h0);
        if_req = 1'b0;
        step();
`else
        chk("rf_nd", {31'd0, if_done}, 32'h0); chk("rf_a0", {16'd0, ram_addr}, 32'h0100);
        repeat (5) step();
        chk("rf_done", {31'd0, if_done}, 32'h1); chk("rf_data", if_data, 32'h44332211);
        if_req = 1'b0;
        step();
`endif

        // byte store into the buffered word forces a full RAM read
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0102; mem_wdata = 32'h00000099; mem_width = 2'b00;
        step(); chk("bs_wr", {31'd0, ram_wr}, 32'h1); chk("bs_d", {24'd0, ram_dout}, 32'h99);
        step(); chk("bs_done", {31'd0, mem_done}, 32'h1);
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        if_req = 1'b1; if_addr = 16'h0100;
        step(); chk("inv_a0", {16'd0, ram_addr}, 32'h0100); chk("inv_nd", {31'd0, if_done}, 32'h0);
        repeat (5) step();
        chk("inv_done", {31'd0, if_done}, 32'h1); chk("inv_data", if_data, 32'h44992211);
        if_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 32, RAM and requester address width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have fetch ports: if_req_i input 1; if_addr_i input ADDR_W; if_data_o output 32; if_done_o output 1.
REQ-005 The block SHALL have data ports:
- mem_req_i input 1; mem_we_i input 1.
- mem_addr_i input ADDR_W; mem_wdata_i input 32.
- mem_width_i input 2, encoded 00 byte, 01 half, 10 word.
- mem_rdata_o output 32; mem_done_o output 1.
REQ-006 The block SHALL have RAM ports: ram_addr_o output ADDR_W; ram_wr_o output 1 (1 means write); ram_dout_o output 8; ram_din_i input 8 (valid one cycle after its address).

Function
REQ-007 The block SHALL share the single byte-wide RAM port between fetch and load/store, using FSM states IDLE, READ and WRITE.
REQ-008 In IDLE, when both requests are high, the block SHALL grant the data port (mem) first; fetch waits.
REQ-009 Transaction length n SHALL be 4 for fetch and 1, 2 or 4 for data, per mem_width_i; mem_width_i=11 SHALL be treated as a word.
REQ-010 Read timing, with T the IDLE cycle that samples the request:
- cycles T+1..T+n drive ram_addr_o = addr+k with ram_wr_o=0;
- byte k is captured in cycle T+k+2, little-endian, zero-extended;
- done and data are registered outputs, valid in cycle T+n+2.
REQ-011 Write timing: cycles T+1..T+n SHALL drive addr+k with ram_wr_o=1 and ram_dout_o = wdata byte k; done SHALL be asserted in cycle T+n+1.
REQ-012 Address increments SHALL wrap modulo 2^ADDR_W.
REQ-013 Each done output SHALL be a one-cycle pulse; the data output SHALL hold its value until the next done for that port.
REQ-014 The FSM SHALL be in IDLE during the done cycle and SHALL ignore both requests in that cycle.
REQ-015 If the granted requester deasserts its request mid-transaction, the FSM SHALL return to IDLE at the next edge:
- no done is issued;
- ram_wr_o=0 from that cycle;
- bytes already written remain written.
REQ-016 Request inputs SHALL be sampled only in IDLE; address, data and width changes during a transaction SHALL be ignored (latched at grant).
REQ-017 When idle, ram_wr_o SHALL be 0 and ram_addr_o SHALL hold its last value.

Reset
REQ-018 rst=0 SHALL asynchronously force:
- state IDLE and byte counter 0;
- all outputs 0: if_data_o, mem_rdata_o, both done outputs, ram_addr_o, ram_wr_o, ram_dout_o;
- fetch buffer invalid.
REQ-019 Reset asserted mid-transaction SHALL abort it with no done pulse.
REQ-020 The first request SHALL be sampled in the first cycle after rst rises.

Configuration
REQ-021 Macro MEM_CTRL_IBUF_EN, when defined, SHALL add a one-entry fetch buffer:
- holds the last fetched word and its word address;
- a fetch hit sampled in IDLE with mem_req_i=0 SHALL give if_done_o and data in T+1, with no RAM access;
- any granted store overlapping the buffered word SHALL invalidate it at grant;
- a completed fetch SHALL refill it.
REQ-022 Without MEM_CTRL_IBUF_EN, every fetch SHALL access RAM; behaviour SHALL be identical to the buffered build for all miss cases.

Structure
REQ-023 A shared definitions header SHALL hold the state encodings, mem_width_i codes and the done/valid constants.
REQ-024 The fetch buffer SHALL be a sub-module mem_ctrl_ibuf, instantiated only under MEM_CTRL_IBUF_EN; all other logic stays in mem_ctrl.

Verification
REQ-025 Word fetch at 0x100, RAM bytes 11,22,33,44 -> addresses 0x100..0x103 in T+1..T+4; if_done_o=1 with if_data_o=0x44332211 in T+6.
REQ-026 Half store of 0xBEEF to 0x200 -> 0xEF@0x200 in T+1, 0xBE@0x201 in T+2, ram_wr_o=1 in both, mem_done_o in T+3.
REQ-027 if_req_i and mem_req_i (byte load at 0x300, RAM=0x80) both high in T -> load first, mem_rdata_o=0x00000080 in T+3; fetch starts in T+4 and completes.
REQ-028 Fetch at 0x100 with if_req_i dropped in T+2 -> FSM in IDLE from T+3, no if_done_o; reset pulse in T+2 of a word store -> all outputs 0 immediately, no mem_done_o.
REQ-029 With MEM_CTRL_IBUF_EN:
- refetch of 0x100 -> if_done_o in T+1, no RAM activity;
- byte store to 0x102, then fetch 0x100 -> full RAM read.
